ram_access_arbiter: RTL

Two-requester arbiter for the single-port 32x8 search RAM. Requester 0 is the binary-search controller (reads); requester 1 is the host loader (reads and writes, e.g. preloading sorted data). The arbiter issues at most one RAM access per cycle. It provides round-robin fairness and an optional lock for atomic sequences, bounded by a preemption timer. It returns read data with a per-requester valid aligned to the RAM read latency.

---
 rtl/ram_access_arbiter_if.sv | 34 +++
 rtl/ram_access_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter_if.sv
// Requester-side bus of the search-RAM arbiter: two request channels plus
// their grants, read-valid strobes and the shared read data.
interface ram_access_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m1_req;
    logic              m0_we;
    logic              m1_we;
    logic              m0_lock;
    logic              m1_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m1_wdata;
    logic              m0_gnt;
    logic              m1_gnt;
    logic              m0_rvalid;
    logic              m1_rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
        output m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata
    );

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Two-requester round-robin arbiter for the single-port search RAM, with an
// optional ownership lock that a waiting requester preempts after MAX_HOLD cycles.
module ram_access_arbiter #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_HOLD    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    ram_access_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    output logic                 ram_wren,
    input  logic [DATA_W-1:0]    ram_q
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic                   last_q, last_d;
    logic                   lock_v_q, lock_v_d;
    logic                   lock_id_q, lock_id_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [RAM_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [RAM_LATENCY-1:0] rd_id_q, rd_id_d;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              expired;
    logic              any_gnt;
    logic              gnt_id;
    logic              sel_we;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [HOLD_W-1:0] hold_inc;

    assign req = {bus.m1_req, bus.m0_req};

    always_comb begin
        expired = lock_v_q && (hold_cnt_q >= HOLD_W'(MAX_HOLD)) && req[!lock_id_q];
        gnt     = '0;
        if (!reset) begin
            // An unexpired lock blocks the other side even while its owner is idle.
            if (lock_v_q && !expired)
                gnt[lock_id_q] = req[lock_id_q];
            else if (&req)
                gnt[!last_q] = 1'b1;
            else
                gnt = req;
        end
    end

    assign any_gnt = |gnt;
    assign gnt_id  = gnt[1];

    always_comb begin
        sel_we    = gnt_id ? bus.m1_we    : bus.m0_we;
        sel_lock  = gnt_id ? bus.m1_lock  : bus.m0_lock;
        sel_addr  = gnt_id ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = gnt_id ? bus.m1_wdata : bus.m0_wdata;
    end

    assign bus.m0_gnt = gnt[0];
    assign bus.m1_gnt = gnt[1];
    assign ram_wren   = any_gnt && sel_we;
    assign ram_addr   = any_gnt ? sel_addr  : '0;
    assign ram_wdata  = any_gnt ? sel_wdata : '0;

    always_comb begin
        hold_inc   = (hold_cnt_q < HOLD_W'(MAX_HOLD)) ? hold_cnt_q + 1'b1 : hold_cnt_q;
        last_d     = last_q;
        lock_v_d   = lock_v_q;
        lock_id_d  = lock_id_q;
        hold_cnt_d = hold_cnt_q;
        if (any_gnt) begin
            last_d = gnt_id;
            if (sel_lock) begin
                if (lock_v_q && (lock_id_q == gnt_id)) begin
                    hold_cnt_d = hold_inc;
                end else begin
                    lock_v_d   = 1'b1;
                    lock_id_d  = gnt_id;
                    hold_cnt_d = '0;
                end
            end else begin
                lock_v_d   = 1'b0;
                hold_cnt_d = '0;
            end
        end else if (lock_v_q) begin
            hold_cnt_d = hold_inc;
        end
    end

    // Read pipe: stage 0 is loaded by a granted read, the last stage lines up with ram_q.
    always_comb begin
        rd_vld_d    = '0;
        rd_id_d     = '0;
        rd_vld_d[0] = any_gnt && !sel_we;
        rd_id_d[0]  = gnt_id;
        for (int s = 1; s < RAM_LATENCY; s++) begin
            rd_vld_d[s] = rd_vld_q[s-1];
            rd_id_d[s]  = rd_id_q[s-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q     <= 1'b1;
            lock_v_q   <= 1'b0;
            lock_id_q  <= 1'b0;
            hold_cnt_q <= '0;
            rd_vld_q   <= '0;
        end else begin
            last_q     <= last_d;
            lock_v_q   <= lock_v_d;
            lock_id_q  <= lock_id_d;
            hold_cnt_q <= hold_cnt_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    always_ff @(posedge clock) begin
        rd_id_q <= rd_id_d;
    end

    assign bus.m0_rvalid = !reset && rd_vld_q[RAM_LATENCY-1] && !rd_id_q[RAM_LATENCY-1];
    assign bus.m1_rvalid = !reset && rd_vld_q[RAM_LATENCY-1] &&  rd_id_q[RAM_LATENCY-1];
    assign bus.rdata     = ram_q;
endmodule
